// File: rtl/prog_sequencer.sv
// prog_sequencer: program-ROM fetch sequencer for the 16-bit multicycle core.
// Optional single-step mode is enabled by defining STEP_MODE_EN.
module prog_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
`ifdef STEP_MODE_EN
    input  logic              Step,
`endif
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [15:0]       MemData,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Fault,
    output logic [ADDR_W-1:0] PC,
    output logic [CNT_W-1:0]  InstrCount
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0] OP_MVI = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPI,
        S_CAPM,
        S_EXEC,
        S_FAULT,
        S_PAUSE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        din_q, din_d;
    logic               run_q, run_d;
    logic [15:0]        instr_q, instr_d;
    logic [15:0]        imm_q, imm_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   icnt_q, icnt_d;
    logic               stop_q, stop_d;
    logic               busy;
    logic               is_mvi;
    logic               stop_now;

    assign busy     = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign is_mvi   = (instr_q[15:13] == OP_MVI);
    assign stop_now = stop_q | Stop;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        din_d   = din_q;
        run_d   = 1'b0;
        instr_d = instr_q;
        imm_d   = imm_q;
        cnt_d   = cnt_q;
        icnt_d  = icnt_q;
        stop_d  = stop_q | (busy & Stop);
        case (state_q)
            S_IDLE: begin
                if (Start && !Stop) begin
                    state_d = S_FETCH;
                    addr_d  = pc_q;
                end
            end
            S_FETCH: begin
                // Present the immediate address early so the ROM word
                // is already on MemData during CAPM.
                addr_d  = pc_q + ADDR_W'(1);
                state_d = S_CAPI;
            end
            S_CAPI: begin
                instr_d = MemData;
                if (MemData[15:13] == OP_MVI) begin
                    state_d = S_CAPM;
                end else begin
                    addr_d  = pc_q;
                    state_d = S_EXEC;
                    run_d   = 1'b1;
                    din_d   = MemData;
                    cnt_d   = '0;
                end
            end
            S_CAPM: begin
                imm_d   = MemData;
                state_d = S_EXEC;
                run_d   = 1'b1;
                din_d   = instr_q;
                cnt_d   = '0;
            end
            S_EXEC: begin
                if (Done && (cnt_q != '0)) begin
                    pc_d   = pc_q + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
                    addr_d = pc_d;
                    icnt_d = icnt_q + CNT_W'(1);
                    if (stop_now) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                    end else begin
`ifdef STEP_MODE_EN
                        state_d = S_PAUSE;
`else
                        state_d = S_FETCH;
`endif
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    run_d = 1'b1;
                    cnt_d = cnt_q + TW'(1);
                    din_d = is_mvi ? imm_q : instr_q;
                end
            end
`ifdef STEP_MODE_EN
            S_PAUSE: begin
                if (stop_now) begin
                    state_d = S_IDLE;
                    stop_d  = 1'b0;
                end else if (Step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            S_FAULT: begin
                stop_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RST;
            addr_q  <= PC_RST;
            din_q   <= '0;
            run_q   <= 1'b0;
            instr_q <= '0;
            imm_q   <= '0;
            cnt_q   <= '0;
            icnt_q  <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            run_q   <= run_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            cnt_q   <= cnt_d;
            icnt_q  <= icnt_d;
            stop_q  <= stop_d;
        end
    end

    assign MemAddr    = addr_q;
    assign DIN        = din_q;
    assign Run        = run_q;
    assign PC         = pc_q;
    assign InstrCount = icnt_q;
    assign Busy       = busy;
    assign Fault      = (state_q == S_FAULT);

endmodule
